// File: rtl/ps2_host_tx.sv
// Purpose : PS/2 host-to-device transmitter; sends one command byte to the keyboard over open-drain ps2_clk/ps2_data.
// Latency : clock inhibit (CLK_HZ*INHIBIT_US/1e6 cycles), then one frame paced by the device clock, then done pulse.
// Backpr. : tx_start is accepted only while busy=0; a request made while busy is dropped, not queued.
//
// Ports:
//   clk50    system clock                  reset_n  synchronous reset, active low
//   tx_data  byte to send (sampled on an accepted tx_start)
//   tx_start 1-cycle send request          ps2c_in/ps2d_in  raw pin levels (asynchronous)
//   ps2c_oe  1 = pull ps2_clk low          ps2d_oe  1 = pull ps2_data low
//   busy     frame in progress             done     1-cycle end-of-frame pulse
//   ack_ok   result qualified by done: 1 = device ACK, 0 = NACK or timeout; held until next start
//
// Build option: define PS2TX_RETRY_EN to automatically re-send the byte once after a NACK or timeout.
module ps2_host_tx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_MS = 15,
    parameter int FILT       = 8
) (
    input  logic       clk50,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok
);

    localparam int INHIBIT_CYC = int'((longint'(CLK_HZ) * longint'(INHIBIT_US)) / 64'sd1_000_000);
    localparam int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int IW = $clog2(INHIBIT_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int FW = $clog2(FILT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAIT_IDLE, S_DONE
    } state_t;

    state_t state, state_nx;

    logic          c_s1, c_s2, d_s1, d_s2;
    logic          c_filt, c_filt_d;
    logic [FW-1:0] flt_cnt;
    logic [FW-1:0] idle_cnt;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    data_q;
    logic [9:0]    shreg;
    logic [3:0]    bit_cnt;
    logic          drive_low;
    logic          fall, inh_hit, tmo_hit, idle_hit;
    logic          can_retry, retry_go, tmo_fail;

    assign fall     = c_filt_d & ~c_filt;
    assign inh_hit  = (inh_cnt == IW'(INHIBIT_CYC - 1));
    assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT_CYC));
    assign idle_hit = (idle_cnt == FW'(FILT - 1)) & c_s2 & d_s2;

`ifdef PS2TX_RETRY_EN
    logic retried;
    assign can_retry = ~retried;
    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            retried <= 1'b0;
        end else if (state == S_IDLE && tx_start) begin
            retried <= 1'b0;
        end else if (retry_go) begin
            retried <= 1'b1;
        end
    end
`else
    assign can_retry = 1'b0;
`endif

    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        retry_go = 1'b0;
        tmo_fail = 1'b0;
        case (state)
            S_IDLE:      if (tx_start) state_nx = S_INHIBIT;
            S_INHIBIT:   if (inh_hit) state_nx = S_START;
            S_START:     state_nx = S_SEND;
            S_SEND:      if (tmo_hit) tmo_fail = 1'b1;
                         else if (fall && bit_cnt == 4'd9) state_nx = S_ACK;
            S_ACK:       if (tmo_hit) tmo_fail = 1'b1;
                         else if (fall) state_nx = S_WAIT_IDLE;
            S_WAIT_IDLE: if (tmo_hit) tmo_fail = 1'b1;
                         else if (idle_hit) begin
                             // A NACK is only acted on once the device has let the bus go idle.
                             if (!ack_ok && can_retry) begin
                                 retry_go = 1'b1;
                                 state_nx = S_INHIBIT;
                             end else begin
                                 state_nx = S_DONE;
                             end
                         end
            S_DONE:      state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
        if (tmo_fail) begin
            if (can_retry) begin
                retry_go = 1'b1;
                state_nx = S_INHIBIT;
            end else begin
                state_nx = S_DONE;
            end
        end

        ps2c_oe = (state == S_INHIBIT) || (state == S_START);
        ps2d_oe = (state == S_START) || (state == S_SEND && drive_low);
        busy    = (state != S_IDLE) && (state != S_DONE);
        done    = (state == S_DONE);
    end

    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            c_s1      <= 1'b1;
            c_s2      <= 1'b1;
            d_s1      <= 1'b1;
            d_s2      <= 1'b1;
            c_filt    <= 1'b1;
            c_filt_d  <= 1'b1;
            flt_cnt   <= '0;
            idle_cnt  <= '0;
            inh_cnt   <= '0;
            tmo_cnt   <= '0;
            data_q    <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            drive_low <= 1'b0;
            ack_ok    <= 1'b0;
        end else begin
            c_s1 <= ps2c_in;
            c_s2 <= c_s1;
            d_s1 <= ps2d_in;
            d_s2 <= d_s1;

            // Clock glitch filter: a new level is adopted only after FILT consecutive differing samples.
            if (c_s2 == c_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILT - 1)) begin
                c_filt  <= c_s2;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
            c_filt_d <= c_filt;

            inh_cnt <= (state == S_INHIBIT && !inh_hit) ? inh_cnt + 1'b1 : '0;

            if (state == S_WAIT_IDLE && c_s2 && d_s2) begin
                if (!idle_hit) idle_cnt <= idle_cnt + 1'b1;
            end else begin
                idle_cnt <= '0;
            end

            if (state == S_START) begin
                tmo_cnt <= '0;
            end else if ((state == S_SEND || state == S_ACK || state == S_WAIT_IDLE) && !tmo_hit) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (state == S_IDLE && tx_start) begin
                data_q <= tx_data;
                ack_ok <= 1'b0;
            end

            // Start bit stays driven in SEND until the device's first falling edge.
            if (state == S_START) begin
                shreg     <= {1'b1, ~^data_q, data_q};
                bit_cnt   <= '0;
                drive_low <= 1'b1;
            end

            if (state == S_SEND && fall) begin
                drive_low <= ~shreg[0];
                shreg     <= {1'b0, shreg[9:1]};
                if (bit_cnt != 4'd9) bit_cnt <= bit_cnt + 1'b1;
            end

            if (state == S_ACK && fall) begin
                ack_ok <= ~d_s2;
            end

            if (tmo_fail) begin
                ack_ok    <= 1'b0;
                drive_low <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Purpose : self-checking bench for ps2_host_tx with a behavioural PS/2 device and a done-driven scoreboard.
// Latency : scaled clock (CLK_HZ = 1 MHz) so inhibit is 100 cycles and timeout 3000 cycles.
// Backpr. : the device model paces every frame; the bench waits on done with bounded budgets.
module tb_ps2_host_tx;

    localparam int CLK_HZ      = 1_000_000;
    localparam int INHIBIT_US  = 100;
    localparam int TIMEOUT_MS  = 3;
    localparam int FILT        = 8;
    localparam int INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
    localparam int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int HALF        = 30;
    localparam int M_ACK       = 0;
    localparam int M_NACK      = 1;
    localparam int M_SILENT    = 2;
`ifdef PS2TX_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic       clk50;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       ps2c_in, ps2d_in;
    logic       ps2c_oe, ps2d_oe, busy, done, ack_ok;

    logic       dev_c, dev_d;
    int         dev_mode;
    bit         dev_busy, dev_abort;
    int         dev_bit;
    logic [9:0] dev_got;

    typedef struct {
        logic [9:0] bits;
        logic       ack;
        int         frames;
        bit         silent;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] cap_q[$];
    exp_t       mon_e;
    logic [9:0] mon_f;

    int tests, fails;
    int cyc, done_cnt, start_cyc, c_low_run;
    logic prev_d_oe;

    // Open-drain bus: either side can pull a line low.
    assign ps2c_in = ~ps2c_oe & dev_c;
    assign ps2d_in = ~ps2d_oe & dev_d;

    ps2_host_tx #(
        .CLK_HZ(CLK_HZ), .INHIBIT_US(INHIBIT_US), .TIMEOUT_MS(TIMEOUT_MS), .FILT(FILT)
    ) dut (
        .clk50(clk50), .reset_n(reset_n), .tx_data(tx_data), .tx_start(tx_start),
        .ps2c_in(ps2c_in), .ps2d_in(ps2d_in), .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe),
        .busy(busy), .done(done), .ack_ok(ack_ok)
    );

    initial clk50 = 1'b0;
    always #5 clk50 = ~clk50;

    task automatic tick(input int n);
        repeat (n) @(posedge clk50);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected wire frame as the device samples it: data LSB first, odd parity, stop=1.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        int   ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        par = (ones % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b};
    endfunction

    // Device model: waits for host request-to-send, then clocks 10 bits in and answers ACK/NACK.
    initial begin
        dev_c = 1'b1; dev_d = 1'b1; dev_busy = 1'b0; dev_abort = 1'b0; dev_bit = 0; dev_got = '0;
        forever begin
            tick(1);
            if (ps2d_in == 1'b0 && ps2c_in == 1'b1 && !dev_abort) begin
                dev_busy = 1'b1;
                if (dev_mode == M_SILENT) begin
                    while (ps2d_in == 1'b0) tick(1);
                end else begin
                    dev_got = '0;
                    tick(40);
                    for (int i = 0; i < 10 && !dev_abort; i++) begin
                        dev_c = 1'b0;
                        tick(HALF);
                        dev_c = 1'b1;
                        tick(2);
                        dev_got[i] = ps2d_in;
                        dev_bit = i + 1;
                        tick(HALF - 2);
                    end
                    if (!dev_abort) begin
                        if (dev_mode == M_ACK) dev_d = 1'b0;
                        tick(15);
                        dev_c = 1'b0;
                        tick(HALF);
                        dev_c = 1'b1;
                        cap_q.push_back(dev_got);
                        tick(HALF);
                        dev_d = 1'b1;
                    end
                end
                dev_c = 1'b1; dev_d = 1'b1; dev_bit = 0; dev_abort = 1'b0;
                dev_busy = 1'b0;
            end
        end
    end

    // Monitor: inhibit length at every start bit, and scoreboard compare at every done pulse.
    initial begin
        cyc = 0; done_cnt = 0; start_cyc = 0; c_low_run = 0; prev_d_oe = 1'b0;
        forever begin
            @(negedge clk50);
            cyc++;
            if (ps2d_oe && !prev_d_oe && ps2c_oe) begin
                check("inhibit_len", 32'(c_low_run >= INHIBIT_CYC), 32'd1);
                start_cyc = cyc;
            end
            c_low_run = ps2c_oe ? c_low_run + 1 : 0;
            prev_d_oe = ps2d_oe;
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 expected no pending request");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ack_ok", 32'(ack_ok), 32'(mon_e.ack));
                    check("busy_at_done", 32'(busy), 32'd0);
                    check("lines_released", 32'({ps2c_oe, ps2d_oe}), 32'd0);
                    check("frame_count", 32'(cap_q.size()), 32'(mon_e.frames));
                    while (cap_q.size() > 0) begin
                        mon_f = cap_q.pop_front();
                        check("frame_bits", 32'(mon_f), 32'(mon_e.bits));
                    end
                    if (mon_e.silent)
                        check("tmo_window", 32'((cyc - start_cyc) >= TIMEOUT_CYC &&
                                                 (cyc - start_cyc) <= TIMEOUT_CYC + 4), 32'd1);
                end
            end
        end
    end

    task automatic wait_dev_idle();
        int n;
        n = 0;
        while (dev_busy && n < 10000) begin tick(1); n++; end
        if (dev_busy) begin
            tests++; fails++;
            $display("FAIL dev_idle_wait: got busy after %0d cycles expected idle", n);
        end
    endtask

    task automatic send(input logic [7:0] b, input int m, input bit mid);
        exp_t e;
        int   d0, n;
        dev_mode = m;
        e.bits   = frame_of(b);
        e.ack    = (m == M_ACK);
        e.frames = (m == M_SILENT) ? 0 : ((m == M_NACK && RETRY) ? 2 : 1);
        e.silent = (m == M_SILENT);
        exp_q.push_back(e);
        d0 = done_cnt;
        tx_data  = b;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        if (mid) begin
            tick(300);
            tx_data  = ~b;
            tx_start = 1'b1;
            tick(1);
            tx_start = 1'b0;
        end
        n = 0;
        while (done_cnt == d0 && n < 20000) begin tick(1); n++; end
        if (done_cnt == d0) begin
            tests++; fails++;
            $display("FAIL done_wait: got no done after %0d cycles expected done", n);
        end
        wait_dev_idle();
        tick(20);
    endtask

    task automatic reset_mid_frame(input logic [7:0] b);
        int n;
        dev_mode = M_ACK;
        tx_data  = b;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        n = 0;
        while (dev_bit != 4 && n < 5000) begin tick(1); n++; end
        check("reached_bit4", 32'(dev_bit), 32'd4);
        dev_abort = 1'b1;
        reset_n   = 1'b0;
        tick(1);
        check("rst_ps2c_oe", 32'(ps2c_oe), 32'd0);
        check("rst_ps2d_oe", 32'(ps2d_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        wait_dev_idle();
        tick(50);
    endtask

    initial begin
        tests = 0; fails = 0;
        reset_n = 1'b0; tx_start = 1'b0; tx_data = '0; dev_mode = M_ACK;
        tick(5);
        check("reset_ps2c_oe", 32'(ps2c_oe), 32'd0);
        check("reset_ps2d_oe", 32'(ps2d_oe), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ack_ok", 32'(ack_ok), 32'd0);
        reset_n = 1'b1;
        tick(20);

        send(8'hED, M_ACK, 1'b0);
        send(8'h00, M_ACK, 1'b0);
        send(8'hA5, M_NACK, 1'b0);
        send(8'h3C, M_SILENT, 1'b0);
        for (int k = 0; k < 6; k++)
            send(8'($urandom_range(0, 255)), int'($urandom_range(0, 1)), 1'b0);
        send(8'h5A, M_ACK, 1'b1);
        reset_mid_frame(8'hC3);
        send(8'h81, M_ACK, 1'b0);

        tick(50);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
